// File: rtl/match_pkg.sv
// Shared state encodings and default sizing for the match window counter.
package match_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int DEFAULT_WIN   = 16;
   localparam int DEFAULT_CNT_W = 8;

endpackage

// File: rtl/match_fifo2.sv
// Two-entry first-in first-out buffer for window counts.
// Occupancy is held as two valid flags so that empty/full come straight from flops.
module match_fifo2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   input  logic         pop_i,
   output logic [W-1:0] data_o,
   output logic         full_o,
   output logic         empty_o,
   output logic         drop_o
);

   logic [W-1:0] head_q, head_d;
   logic [W-1:0] tail_q, tail_d;
   logic         head_vld_q, head_vld_d;
   logic         tail_vld_q, tail_vld_d;
   logic         do_pop;

   assign empty_o = !head_vld_q;
   assign full_o  = tail_vld_q;
   assign data_o  = head_q;
   assign do_pop  = pop_i && head_vld_q;
   assign drop_o  = push_i && tail_vld_q && !do_pop;

   // NOTE: every _d gets its hold value before any branch; a path that skips an assignment would infer a latch.
   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      head_vld_d = head_vld_q;
      tail_vld_d = tail_vld_q;
      if (!head_vld_q) begin
         if (push_i) begin
            head_d     = data_i;
            head_vld_d = 1'b1;
         end
      end else if (!tail_vld_q) begin
         if (push_i && do_pop) begin
            head_d = data_i;
         end else if (push_i) begin
            tail_d     = data_i;
            tail_vld_d = 1'b1;
         end else if (do_pop) begin
            head_vld_d = 1'b0;
         end
      end else if (do_pop) begin
         head_d = tail_q;
         if (push_i) begin
            tail_d = data_i;
         end else begin
            tail_vld_d = 1'b0;
         end
      end
   end

   // NOTE: non-blocking assignments in clocked blocks, so every flop samples the pre-edge value of the others.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the storage words are reset as well, because head_q drives the count output and must read 0 after reset.
         head_q     <= '0;
         tail_q     <= '0;
         head_vld_q <= 1'b0;
         tail_vld_q <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         head_vld_q <= head_vld_d;
         tail_vld_q <= tail_vld_d;
      end
   end

endmodule

// File: rtl/match_window_counter.sv
// Counts recognizer match pulses per WIN-cycle window and queues each count for a valid/ready consumer.
// Define MATCH_CNT_SATURATE_EN to clamp the count at its maximum instead of wrapping.
module match_window_counter
   import match_pkg::*;
#(
   parameter int WIN   = DEFAULT_WIN,
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             match,
   input  logic             en,
   output logic [CNT_W-1:0] cnt_data,
   output logic             cnt_valid,
   input  logic             cnt_ready,
   output logic             overflow
);

   localparam int              WC_W = (WIN > 1) ? $clog2(WIN) : 1;
   localparam logic [WC_W-1:0] LAST = WC_W'(WIN - 1);

   state_t           state_q, state_d;
   logic [WC_W-1:0]  win_cnt_q, win_cnt_d;
   logic [CNT_W-1:0] acc_q, acc_d, acc_sum;
   logic             overflow_q, overflow_d;
   logic             push;
   logic             fifo_empty, fifo_full, fifo_drop;

   function automatic logic [CNT_W-1:0] acc_add(input logic [CNT_W-1:0] a, input logic m);
`ifdef MATCH_CNT_SATURATE_EN
      return (m && (&a)) ? a : a + CNT_W'(m);
`else
      return a + CNT_W'(m);
`endif
   endfunction

   assign acc_sum = acc_add(acc_q, match);

   always_comb begin
      state_d   = state_q;
      win_cnt_d = win_cnt_q;
      acc_d     = acc_q;
      push      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            win_cnt_d = '0;
            acc_d     = '0;
            if (en) state_d = ST_RUN;
         end
         ST_RUN: begin
            // The closing cycle pushes even when en is falling in that same cycle.
            push = (win_cnt_q == LAST);
            if (!en || push) begin
               win_cnt_d = '0;
               acc_d     = '0;
            end else begin
               win_cnt_d = win_cnt_q + WC_W'(1);
               acc_d     = acc_sum;
            end
            if (!en) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign overflow_d = overflow_q || fifo_drop;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         win_cnt_q  <= '0;
         acc_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         win_cnt_q  <= win_cnt_d;
         acc_q      <= acc_d;
         overflow_q <= overflow_d;
      end
   end

   match_fifo2 #(.W(CNT_W)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .data_i  (acc_sum),
      .pop_i   (cnt_ready),
      .data_o  (cnt_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .drop_o  (fifo_drop)
   );

   assign cnt_valid = !fifo_empty;
   assign overflow  = overflow_q;

   // Counts are only ever lost when both slots are occupied.
   assert property (@(posedge clk) disable iff (reset) fifo_drop |-> fifo_full);

endmodule

// File: tb/tb_match_window_counter.sv
// Self-checking bench: two counters (8-bit and 2-bit counts) against a queue-based window model.
module tb_match_window_counter;

   localparam int WIN = 8;

   logic       clk = 1'b0;
   logic       reset, match, en, cnt_ready;
   logic [7:0] data8;
   logic [1:0] data2;
   logic       valid8, valid2, ovf8, ovf2;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   match_window_counter #(.WIN(WIN), .CNT_W(8)) dut8 (
      .clk(clk), .reset(reset), .match(match), .en(en),
      .cnt_data(data8), .cnt_valid(valid8), .cnt_ready(cnt_ready), .overflow(ovf8)
   );

   match_window_counter #(.WIN(WIN), .CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .match(match), .en(en),
      .cnt_data(data2), .cnt_valid(valid2), .cnt_ready(cnt_ready), .overflow(ovf2)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: true (unbounded) window tallies held in a 2-deep queue.
   bit m_run;
   int m_pos, m_tally;
   int m_buf[$];
   bit m_ovf;

   function automatic int exp_data(input int c, input int w);
      int mx;
      mx = (1 << w) - 1;
`ifdef MATCH_CNT_SATURATE_EN
      return (c > mx) ? mx : c;
`else
      return c & mx;
`endif
   endfunction

   always @(posedge clk) begin : model
      bit pop, push;
      int val;
      pop  = (m_buf.size() > 0) && (cnt_ready === 1'b1);
      push = 1'b0;
      val  = 0;
      if (reset) begin
         m_run = 1'b0; m_pos = 0; m_tally = 0; m_ovf = 1'b0;
         m_buf.delete();
      end else begin
         if (m_run) begin
            m_tally += int'(match);
            if (m_pos == WIN - 1) begin
               push = 1'b1;
               val  = m_tally;
            end
            if (!en || push) begin
               m_pos = 0; m_tally = 0;
            end else begin
               m_pos++;
            end
            m_run = en;
         end else if (en) begin
            m_run = 1'b1; m_pos = 0; m_tally = 0;
         end
         if (pop) void'(m_buf.pop_front());
         if (push) begin
            if (m_buf.size() < 2) m_buf.push_back(val);
            else m_ovf = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("m_valid8", {31'd0, valid8}, {31'd0, m_buf.size() > 0});
         check("m_valid2", {31'd0, valid2}, {31'd0, m_buf.size() > 0});
         check("m_ovf8", {31'd0, ovf8}, {31'd0, m_ovf});
         check("m_ovf2", {31'd0, ovf2}, {31'd0, m_ovf});
         if (m_buf.size() > 0) begin
            check("m_data8", {24'd0, data8}, exp_data(m_buf[0], 8));
            check("m_data2", {30'd0, data2}, exp_data(m_buf[0], 2));
         end
      end
   end

   // en rises with a match in the same cycle; that match must be ignored.
   task automatic start();
      en = 1'b1; match = 1'b1;
      @(negedge clk);
      match = 1'b0;
   endtask

   task automatic stop();
      en = 1'b0; match = 1'b0;
      @(negedge clk);
   endtask

   task automatic run_window(input logic [WIN-1:0] pat);
      for (int k = 0; k < WIN; k++) begin
         match = pat[k];
         @(negedge clk);
      end
      match = 1'b0;
   endtask

   initial begin
      logic [WIN-1:0] pat;
      reset = 1'b1; en = 1'b0; match = 1'b0; cnt_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      check("rst_valid", {31'd0, valid8}, 0);
      check("rst_data", {24'd0, data8}, 0);
      check("rst_ovf", {31'd0, ovf8}, 0);
      reset = 1'b0;

      // Pulses at window cycles 2, 4, 6 then an empty window.
      start();
      run_window(8'b0101_0100);
      check("t1_valid", {31'd0, valid8}, 1);
      check("t1_data", {24'd0, data8}, 3);
      match = 1'b0;
      @(negedge clk);
      check("t1_one_cycle", {31'd0, valid8}, 0);
      repeat (WIN - 1) @(negedge clk);
      check("t1_zero_valid", {31'd0, valid8}, 1);
      check("t1_zero_data", {24'd0, data8}, 0);

      // Stalled consumer over three windows: third count is dropped.
      stop();
      cnt_ready = 1'b0;
      start();
      run_window(8'b0000_0001);
      check("t2_first", {24'd0, data8}, 1);
      run_window(8'b0000_0011);
      run_window(8'b0000_0111);
      check("t2_ovf", {31'd0, ovf8}, 1);
      check("t2_head", {24'd0, data8}, 1);
      cnt_ready = 1'b1;
      @(negedge clk);
      check("t2_second", {24'd0, data8}, 2);
      check("t2_second_v", {31'd0, valid8}, 1);
      @(negedge clk);
      check("t2_drained", {31'd0, valid8}, 0);
      check("t2_ovf_sticky", {31'd0, ovf8}, 1);

      // en dropped mid-window discards the partial count.
      stop();
      start();
      for (int k = 0; k < 4; k++) begin
         match = (k == 1 || k == 3);
         @(negedge clk);
      end
      en = 1'b0; match = 1'b1;
      @(negedge clk);
      match = 1'b0;
      repeat (2) @(negedge clk);
      check("t3_no_out", {31'd0, valid8}, 0);
      start();
      run_window(8'b0000_0001);
      check("t3_fresh", {24'd0, data8}, 1);

      // Match every cycle: 8 counts into an 8-bit and a 2-bit accumulator.
      stop();
      start();
      run_window(8'hFF);
      check("t4_data8", {24'd0, data8}, 8);
      check("t4_valid2", {31'd0, valid2}, 1);
`ifdef MATCH_CNT_SATURATE_EN
      check("t4_data2", {30'd0, data2}, 3);
`else
      check("t4_data2", {30'd0, data2}, 0);
`endif

      // Full buffer, window closes while the consumer pops: nothing lost.
      reset = 1'b1; en = 1'b0;
      @(negedge clk);
      reset = 1'b0; cnt_ready = 1'b0;
      start();
      run_window(8'b0000_0001);
      run_window(8'b0000_0011);
      pat = 8'b0000_1111;
      for (int k = 0; k < WIN; k++) begin
         match = pat[k];
         cnt_ready = (k == WIN - 1);
         @(negedge clk);
      end
      match = 1'b0; cnt_ready = 1'b0;
      check("t5_no_ovf", {31'd0, ovf8}, 0);
      check("t5_head", {24'd0, data8}, 2);
      cnt_ready = 1'b1;
      @(negedge clk);
      check("t5_tail", {24'd0, data8}, 4);
      @(negedge clk);
      check("t5_empty", {31'd0, valid8}, 0);

      // Reset mid-window with the buffer full and overflow set.
      cnt_ready = 1'b0;
      stop();
      start();
      repeat (3) run_window(8'b0000_0001);
      check("t6_ovf_set", {31'd0, ovf8}, 1);
      match = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("t6_valid", {31'd0, valid8}, 0);
      check("t6_data8", {24'd0, data8}, 0);
      check("t6_data2", {30'd0, data2}, 0);
      check("t6_ovf8", {31'd0, ovf8}, 0);
      check("t6_ovf2", {31'd0, ovf2}, 0);
      reset = 1'b0; cnt_ready = 1'b1;
      @(negedge clk);
      check("t6_idle", {31'd0, valid8}, 0);
      match = 1'b0;
      run_window(8'b1000_0001);
      check("t6_restart_v", {31'd0, valid8}, 1);
      check("t6_restart_d", {24'd0, data8}, 2);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
